ccm_ctr_stream: RTL and testbench



---
 rtl/ccm_ctr_stream.sv | 210 +++++++++++++++++++++
 tb/tb_ccm_ctr_stream.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccm_ctr_stream.sv
// Counter-mode stream engine: packs DATA_W beats into 128-bit blocks, XORs each
// block with a {flag, nonce, count} keystream and drains through ping-pong buffers.
module ccm_ctr_stream #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WIDTH_NONCE = 104,
    parameter int unsigned WIDTH_FLAG  = 8,
    parameter int unsigned WIDTH_COUNT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH_COUNT-1:0] ctr_init,
    input  logic [127:0]           key_aes,
    input  logic [WIDTH_NONCE-1:0] ctr_nonce,
    input  logic [WIDTH_FLAG-1:0]  ctr_flag,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   ctr_wrap
);

    localparam int unsigned BLK_W = 128;
    localparam int unsigned BEATS = BLK_W / DATA_W;
    localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned NB_W  = $clog2(BEATS + 1);
    localparam int unsigned SH_W  = 7;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    if (WIDTH_FLAG + WIDTH_NONCE + WIDTH_COUNT != BLK_W) begin : g_bad_ctr_width
        $error("ccm_ctr_stream: flag+nonce+count widths must total 128");
    end
    if ((DATA_W < 8) || (DATA_W * BEATS != BLK_W)) begin : g_bad_data_w
        $error("ccm_ctr_stream: DATA_W must be one of 8/16/32/64/128");
    end

    // Per-buffer storage (index 0 = A, 1 = B)
    logic [1:0]             r_state [2];
    logic [BLK_W-1:0]       r_buf   [2];
    logic [NB_W-1:0]        r_n     [2];
    logic                   r_last  [2];
    logic [WIDTH_COUNT-1:0] r_cnt   [2];

    logic                   r_fill_sel, r_drain_sel;
    logic [IDX_W-1:0]       r_in_idx, r_rd_idx;
    logic [WIDTH_COUNT-1:0] r_count;
    logic                   r_wrap;
    logic                   r_in_ready;
    logic                   r_out_valid, r_out_last, r_out_final;
    logic [DATA_W-1:0]      r_out_data;

    logic [1:0]             w_state [2];
    logic [BLK_W-1:0]       w_buf   [2];
    logic [NB_W-1:0]        w_n     [2];
    logic                   w_last  [2];
    logic [WIDTH_COUNT-1:0] w_cnt   [2];

    logic                   w_fill_sel, w_drain_sel;
    logic [IDX_W-1:0]       w_in_idx, w_rd_idx;
    logic [WIDTH_COUNT-1:0] w_count;
    logic                   w_wrap;
    logic                   w_in_ready;
    logic                   w_out_valid, w_out_last, w_out_final;
    logic [DATA_W-1:0]      w_out_data;

    logic                   w_acc_in, w_acc_out, w_close, w_free, w_src_ok;
    logic [SH_W-1:0]        w_wsh, w_rsh;
    logic [BLK_W-1:0]       w_blk;

    // Next-state: drain completion, fill, then output load from the post-fill view
    always_comb begin
        w_state     = r_state;
        w_buf       = r_buf;
        w_n         = r_n;
        w_last      = r_last;
        w_cnt       = r_cnt;
        w_fill_sel  = r_fill_sel;
        w_drain_sel = r_drain_sel;
        w_in_idx    = r_in_idx;
        w_rd_idx    = r_rd_idx;
        w_count     = r_count;
        w_wrap      = r_wrap;
        w_out_valid = r_out_valid;
        w_out_last  = r_out_last;
        w_out_final = r_out_final;
        w_out_data  = r_out_data;
        w_blk       = '0;
        w_rsh       = '0;

        w_acc_in  = in_valid & r_in_ready;
        w_acc_out = r_out_valid & out_ready;
        w_close   = w_acc_in & (in_last | (r_in_idx == IDX_W'(BEATS - 1)));
        w_wsh     = SH_W'((BEATS - 1 - 32'(r_in_idx)) * DATA_W);
        w_free    = ~r_out_valid | out_ready;

        if (w_acc_out) begin
            w_out_valid = 1'b0;
            w_out_last  = 1'b0;
            w_out_final = 1'b0;
            if (r_out_final) begin
                w_state[r_drain_sel] = ST_EMPTY;
                w_drain_sel          = ~r_drain_sel;
                w_rd_idx             = '0;
            end
        end

        if (w_acc_in) begin
            w_buf[r_fill_sel]   = (r_buf[r_fill_sel] & ~(BLK_W'({DATA_W{1'b1}}) << w_wsh))
                                | (BLK_W'(in_data) << w_wsh);
            w_state[r_fill_sel] = ST_FILL;
            w_in_idx            = r_in_idx + IDX_W'(1);
            if (w_close) begin
                w_state[r_fill_sel] = ST_FULL;
                w_n[r_fill_sel]     = NB_W'(r_in_idx) + NB_W'(1);
                w_last[r_fill_sel]  = in_last;
                w_cnt[r_fill_sel]   = r_count;
                w_fill_sel          = ~r_fill_sel;
                w_in_idx            = '0;
                w_count             = r_count + WIDTH_COUNT'(1);
                if (&r_count) begin
                    w_wrap = 1'b1;
                end
            end
        end

        // A DRAINING buffer whose final beat is already presented has nothing left to load
        w_src_ok = (w_state[w_drain_sel] == ST_FULL)
                 | ((w_state[w_drain_sel] == ST_DRAIN) & ~r_out_final);

        if (w_free && w_src_ok) begin
            w_blk       = w_buf[w_drain_sel]
                        ^ ({ctr_flag, ctr_nonce, w_cnt[w_drain_sel]} ^ key_aes);
            w_rsh       = SH_W'((BEATS - 1 - 32'(w_rd_idx)) * DATA_W);
            w_out_data  = DATA_W'(w_blk >> w_rsh);
            w_out_valid = 1'b1;
            w_out_final = (NB_W'(w_rd_idx) + NB_W'(1)) == w_n[w_drain_sel];
            w_out_last  = w_out_final & w_last[w_drain_sel];
            w_state[w_drain_sel] = ST_DRAIN;
            w_rd_idx    = w_out_final ? '0 : (w_rd_idx + IDX_W'(1));
        end

        if (start) begin
            w_state     = '{default: ST_EMPTY};
            w_fill_sel  = 1'b0;
            w_drain_sel = 1'b0;
            w_in_idx    = '0;
            w_rd_idx    = '0;
            w_count     = ctr_init;
            w_wrap      = 1'b0;
            w_out_valid = 1'b0;
            w_out_last  = 1'b0;
            w_out_final = 1'b0;
        end

        w_in_ready = (w_state[w_fill_sel] == ST_EMPTY) | (w_state[w_fill_sel] == ST_FILL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= '{default: ST_EMPTY};
            r_buf       <= '{default: '0};
            r_n         <= '{default: '0};
            r_last      <= '{default: 1'b0};
            r_cnt       <= '{default: '0};
            r_fill_sel  <= 1'b0;
            r_drain_sel <= 1'b0;
            r_in_idx    <= '0;
            r_rd_idx    <= '0;
            r_count     <= WIDTH_COUNT'(1);
            r_wrap      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_final <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state;
            r_buf       <= w_buf;
            r_n         <= w_n;
            r_last      <= w_last;
            r_cnt       <= w_cnt;
            r_fill_sel  <= w_fill_sel;
            r_drain_sel <= w_drain_sel;
            r_in_idx    <= w_in_idx;
            r_rd_idx    <= w_rd_idx;
            r_count     <= w_count;
            r_wrap      <= w_wrap;
            r_in_ready  <= w_in_ready;
            r_out_valid <= w_out_valid;
            r_out_last  <= w_out_last;
            r_out_final <= w_out_final;
            r_out_data  <= w_out_data;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign ctr_wrap  = r_wrap;

endmodule

// File: tb/tb_ccm_ctr_stream.sv
// Scoreboard bench for ccm_ctr_stream: an 8-bit instance (a) and a 32-bit instance (b).
`timescale 1ns/1ps
module tb_ccm_ctr_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    // Instance a: DATA_W = 8
    logic         reset_a = 1'b1, start_a = 1'b0, vin_a = 1'b0, lin_a = 1'b0, ordy_a = 1'b1;
    logic [15:0]  init_a  = '0;
    logic [127:0] key_a   = '0;
    logic [103:0] nonce_a = '0;
    logic [7:0]   flag_a  = '0;
    logic [7:0]   din_a   = '0;
    logic         rdy_a, vout_a, lout_a, wrap_a;
    logic [7:0]   dout_a;

    // Instance b: DATA_W = 32
    logic         reset_b = 1'b1, start_b = 1'b0, vin_b = 1'b0, lin_b = 1'b0, ordy_b = 1'b1;
    logic [15:0]  init_b  = '0;
    logic [127:0] key_b   = '0;
    logic [103:0] nonce_b = '0;
    logic [7:0]   flag_b  = '0;
    logic [31:0]  din_b   = '0;
    logic         rdy_b, vout_b, lout_b, wrap_b;
    logic [31:0]  dout_b;

    ccm_ctr_stream #(.DATA_W(8)) u_dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .ctr_init(init_a), .key_aes(key_a),
        .ctr_nonce(nonce_a), .ctr_flag(flag_a), .in_data(din_a), .in_valid(vin_a),
        .in_last(lin_a), .in_ready(rdy_a), .out_data(dout_a), .out_valid(vout_a),
        .out_ready(ordy_a), .out_last(lout_a), .ctr_wrap(wrap_a)
    );

    ccm_ctr_stream #(.DATA_W(32)) u_dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .ctr_init(init_b), .key_aes(key_b),
        .ctr_nonce(nonce_b), .ctr_flag(flag_b), .in_data(din_b), .in_valid(vin_b),
        .in_last(lin_b), .in_ready(rdy_b), .out_data(dout_b), .out_valid(vout_b),
        .out_ready(ordy_b), .out_last(lout_b), .ctr_wrap(wrap_b)
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] ksf(input logic [7:0] f, input logic [103:0] n,
                                         input logic [15:0] c, input logic [127:0] k);
        return {f, n, c} ^ k;
    endfunction

    task automatic push_a(input logic [7:0] d, input int j, input logic [15:0] c, input logic l);
        logic [127:0] ks;
        exp_t         e;
        ks  = ksf(flag_a, nonce_a, c, key_a) >> (120 - 8 * j);
        e.d = {24'h0, d ^ ks[7:0]};
        e.l = l;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [31:0] d, input int j, input logic [15:0] c, input logic l);
        logic [127:0] ks;
        exp_t         e;
        ks  = ksf(flag_b, nonce_b, c, key_b) >> (96 - 32 * j);
        e.d = d ^ ks[31:0];
        e.l = l;
        q_b.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 just after the beat was taken
    task automatic send_a(input logic [7:0] d, input logic l, output int waits);
        din_a = d; vin_a = 1'b1; lin_a = l; waits = 0;
        @(negedge clk);
        while (!rdy_a) begin
            waits++;
            if (waits > 200) begin
                n_vec++; n_err++;
                $display("FAIL send_a: in_ready stayed 0, expected 1");
                vin_a = 1'b0;
                return;
            end
            @(negedge clk);
        end
        tick();
    endtask

    task automatic send_b(input logic [31:0] d, input logic l);
        int waits;
        din_b = d; vin_b = 1'b1; lin_b = l; waits = 0;
        @(negedge clk);
        while (!rdy_b) begin
            waits++;
            if (waits > 200) begin
                n_vec++; n_err++;
                $display("FAIL send_b: in_ready stayed 0, expected 1");
                vin_b = 1'b0;
                return;
            end
            @(negedge clk);
        end
        tick();
    endtask

    task automatic drain_a(input string nm);
        for (int i = 0; i < 1000; i++) begin
            if (q_a.size() == 0 && !vout_a) break;
            tick();
        end
        chk(nm, 128'(q_a.size()), 128'd0);
    endtask

    task automatic drain_b(input string nm);
        for (int i = 0; i < 1000; i++) begin
            if (q_b.size() == 0 && !vout_b) break;
            tick();
        end
        chk(nm, 128'(q_b.size()), 128'd0);
    endtask

    task automatic start_pulse_a(input logic [15:0] v);
        init_a = v; start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    // Scoreboard monitors: compare on every accepted output beat
    always @(negedge clk) begin
        if (vout_a && ordy_a) begin
            if (q_a.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL out_a: got unexpected beat %0h, expected none", dout_a);
            end else begin
                e_a = q_a.pop_front();
                chk("out_a", 128'({dout_a, lout_a}), 128'({e_a.d[7:0], e_a.l}));
            end
        end
    end

    always @(negedge clk) begin
        if (vout_b && ordy_b) begin
            if (q_b.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL out_b: got unexpected beat %0h, expected none", dout_b);
            end else begin
                e_b = q_b.pop_front();
                chk("out_b", 128'({dout_b, lout_b}), 128'({e_b.d, e_b.l}));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          waits;
        int          total;
        int          acc;
        logic [7:0]  d8;
        logic [7:0]  held;
        logic [7:0]  t1_exp [16];

        t1_exp = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready_a", 128'(rdy_a), 128'd0);
        chk("rst_out_valid_a", 128'(vout_a), 128'd0);
        chk("rst_out_data_a", 128'(dout_a), 128'd0);
        chk("rst_out_last_a", 128'(lout_a), 128'd0);
        chk("rst_wrap_a", 128'(wrap_a), 128'd0);
        chk("rst_in_ready_b", 128'(rdy_b), 128'd0);
        tick();
        reset_a = 1'b0; reset_b = 1'b0;
        tick();
        @(negedge clk);
        chk("post_rst_in_ready_a", 128'(rdy_a), 128'd1);
        tick();

        // Streaming: 48 bytes from reset, counts 1,2,3, no input bubbles
        key_a   = {16{8'hA5}};
        flag_a  = 8'h59;
        nonce_a = 104'h00_1122_3344_5566_7788_99AA_BBCC;
        total   = 0;
        for (int i = 0; i < 48; i++) begin
            d8 = 8'($urandom);
            push_a(d8, i % 16, 16'(1 + i / 16), i == 47);
            send_a(d8, i == 47, waits);
            total += waits;
        end
        vin_a = 1'b0; lin_a = 1'b0;
        chk("stream_in_ready_bubbles", 128'(total), 128'd0);
        drain_a("stream_drain");

        // Single block, hand-computed keystream
        key_a = '0; flag_a = 8'h01; nonce_a = '0;
        start_pulse_a(16'h0001);
        for (int i = 0; i < 16; i++) q_a.push_back('{d: {24'h0, t1_exp[i]}, l: (i == 15)});
        for (int i = 0; i < 15; i++) send_a(8'h00, 1'b0, waits);
        vin_a = 1'b0;
        @(negedge clk);
        chk("t1_no_early_valid", 128'(vout_a), 128'd0);
        tick();
        send_a(8'h00, 1'b1, waits);
        vin_a = 1'b0; lin_a = 1'b0;
        @(negedge clk);
        chk("t1_latency", 128'(vout_a), 128'd1);
        tick();
        drain_a("t1_drain");

        // Partial final block, then a new message restarting at ctr_init
        key_a = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
        flag_a = 8'h5A; nonce_a = 104'hDE_ADBE_EF01_0203_0405_0607_0809;
        start_pulse_a(16'h0001);
        for (int i = 0; i < 19; i++) begin
            d8 = 8'(i * 7 + 3);
            push_a(d8, i % 16, 16'(1 + i / 16), i == 18);
            send_a(d8, i == 18, waits);
        end
        vin_a = 1'b0; lin_a = 1'b0;
        drain_a("partial_drain");
        start_pulse_a(16'h0040);
        for (int i = 0; i < 2; i++) begin
            d8 = 8'(8'hC0 + i);
            push_a(d8, i, 16'h0040, i == 1);
            send_a(d8, i == 1, waits);
        end
        vin_a = 1'b0; lin_a = 1'b0;
        drain_a("partial_next_msg_drain");

        // Backpressure: 60 cycles offered, two buffers' worth accepted
        start_pulse_a(16'h0010);
        ordy_a = 1'b0;
        acc    = 0;
        held   = '0;
        for (int c = 0; c < 60; c++) begin
            din_a = 8'(acc + 8'h30); vin_a = 1'b1; lin_a = 1'b0;
            @(negedge clk);
            if (c == 40) held = dout_a;
            if (rdy_a) begin
                push_a(din_a, acc % 16, 16'(16'h0010 + acc / 16), 1'b0);
                acc++;
            end
            tick();
        end
        chk("bp_accepted", 128'(acc), 128'd32);
        @(negedge clk);
        chk("bp_in_ready_low", 128'(rdy_a), 128'd0);
        chk("bp_out_valid_held", 128'(vout_a), 128'd1);
        chk("bp_out_data_stable", 128'(dout_a), 128'(held));
        vin_a = 1'b0;
        tick();
        ordy_a = 1'b1;
        drain_a("bp_drain");

        // Restart mid-drain
        key_a = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        flag_a = 8'h33; nonce_a = 104'h01_0101_0101_0101_0101_0101_0101;
        start_pulse_a(16'h0020);
        ordy_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            d8 = 8'(8'h80 + i);
            if (i < 4) push_a(d8, i, 16'h0020, 1'b0);
            send_a(d8, 1'b0, waits);
        end
        vin_a = 1'b0;
        @(negedge clk);
        chk("rs_valid_before", 128'(vout_a), 128'd1);
        tick();
        ordy_a = 1'b1;
        repeat (4) tick();
        ordy_a = 1'b0;
        start_pulse_a(16'h0007);
        @(negedge clk);
        chk("rs_valid_drop", 128'(vout_a), 128'd0);
        chk("rs_in_ready", 128'(rdy_a), 128'd1);
        chk("rs_sb_empty", 128'(q_a.size()), 128'd0);
        tick();
        ordy_a = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d8 = 8'(8'h4C + i);
            push_a(d8, i, 16'h0007, i == 1);
            send_a(d8, i == 1, waits);
        end
        vin_a = 1'b0; lin_a = 1'b0;
        drain_a("rs_drain");

        // 32-bit instance: counter wrap
        key_b = 128'hCAFE_F00D_0123_4567_89AB_CDEF_FEDC_BA98;
        flag_b = 8'h7E; nonce_b = 104'hAB_CDEF_0011_2233_4455_6677_8899;
        init_b = 16'hFFFF; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_b(32'h1000_0000 + 32'(i), i, 16'hFFFF, 1'b0);
            send_b(32'h1000_0000 + 32'(i), 1'b0);
        end
        vin_b = 1'b0;
        @(negedge clk);
        chk("wrap_before_close", 128'(wrap_b), 128'd0);
        tick();
        push_b(32'h1000_0003, 3, 16'hFFFF, 1'b0);
        send_b(32'h1000_0003, 1'b0);
        vin_b = 1'b0;
        @(negedge clk);
        chk("wrap_after_close", 128'(wrap_b), 128'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            push_b(32'hA5A5_0000 + 32'(i * 32'h111), i, 16'h0000, i == 3);
            send_b(32'hA5A5_0000 + 32'(i * 32'h111), i == 3);
        end
        vin_b = 1'b0; lin_b = 1'b0;
        drain_b("wrap_drain");
        chk("wrap_sticky", 128'(wrap_b), 128'd1);
        init_b = 16'h0005; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        @(negedge clk);
        chk("wrap_cleared_by_start", 128'(wrap_b), 128'd0);
        tick();

        repeat (5) tick();
        chk("final_sb_a", 128'(q_a.size()), 128'd0);
        chk("final_sb_b", 128'(q_b.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
